// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo: write/read requests, read data,
// occupancy and sticky error flags.
interface param_fifo_if #(
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 3
);
  logic                wen;
  logic [WIDTH-1:0]    in;
  logic                ren;
  logic                clr_err;
  logic [WIDTH-1:0]    out;
  logic                valid;
  logic                empty;
  logic                full;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDR_BIT:0]   cnt;
  logic [ADDR_BIT:0]   gray_cnt;
  logic                overflow;
  logic                underflow;

  modport master (
    output wen, in, ren, clr_err,
    input  out, valid, empty, full, almost_full, almost_empty,
           cnt, gray_cnt, overflow, underflow
  );

  modport slave (
    input  wen, in, ren, clr_err,
    output out, valid, empty, full, almost_full, almost_empty,
           cnt, gray_cnt, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered-read or first-word-fall-through
// output, threshold flags, Gray-coded occupancy and sticky overflow/underflow.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 3,
  parameter int FWFT     = 0,
  parameter int AF_TH    = (2 ** ADDR_BIT) - 1,
  parameter int AE_TH    = 1
) (
  input  logic         clk,
  input  logic         rst,
  param_fifo_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BIT;

  typedef logic [ADDR_BIT-1:0] ptr_t;
  typedef logic [ADDR_BIT:0]   cnt_t;
  typedef logic [WIDTH-1:0]    word_t;

  word_t mem [DEPTH];
  ptr_t  front, rear, front_next;
  cnt_t  cnt, cnt_next;
  word_t out_q;
  logic  overflow_q, underflow_q;
  logic  empty, full;
  logic  wacc, racc;

  // Flags decode the registered occupancy, so they never glitch on inputs.
  assign empty = (cnt == '0);
  assign full  = (cnt == cnt_t'(DEPTH));

  assign wacc = bus.wen && !full;
  assign racc = bus.ren && !empty;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    front_next = front;
    cnt_next   = cnt;
    if (racc) front_next = front + ptr_t'(1);
    unique case ({wacc, racc})
      2'b10:   cnt_next = cnt + cnt_t'(1);
      2'b01:   cnt_next = cnt - cnt_t'(1);
      default: cnt_next = cnt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      front <= '0;
      rear  <= '0;
      cnt   <= '0;
    end else begin
      front <= front_next;
      if (wacc) rear <= rear + ptr_t'(1);
      cnt   <= cnt_next;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (wacc && !rst) mem[rear] <= bus.in;
  end

  // Sticky errors: a coincident error event beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wen && full)   overflow_q  <= 1'b1;
      else if (bus.clr_err)  overflow_q  <= 1'b0;
      if (bus.ren && empty)  underflow_q <= 1'b1;
      else if (bus.clr_err)  underflow_q <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_registered
      logic valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= racc;
          if (racc) out_q <= mem[front];
        end
      end

      assign bus.valid = valid_q;
    end else begin : g_fwft
      word_t head_next;

      // The post-edge head is the word just written when it lands exactly
      // at the new front (write into empty, or write+read at one entry).
      always_comb begin
        head_next = out_q;
        if (cnt_next != '0) begin
          if (wacc && (front_next == rear)) head_next = bus.in;
          else                              head_next = mem[front_next];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= head_next;
      end

      assign bus.valid = !empty;
    end
  endgenerate

  assign bus.out          = out_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (cnt >= cnt_t'(AF_TH));
  assign bus.almost_empty = (cnt <= cnt_t'(AE_TH));
  assign bus.cnt          = cnt;
  assign bus.gray_cnt     = cnt ^ (cnt >> 1);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
